instr_encoder_loader: RTL and testbench

- Inverse of the instruction field splitter: takes decoded MIPS fields, packs them into 32-bit R/I/J words, and writes them in order into instruction memory through a single write port.
- Used by the boot/test loader path to fill instruction memory before the CPU is released from reset.
- Input side is a valid/ready handshake; output side is a one-cycle memory write strobe.
- A small FSM controls the write address, the word count, and full/last/error termination.

---
 rtl/instr_encoder_loader.sv | 123 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS R/I/J fields into 32-bit words and writes them in order
// into instruction memory, one word per two cycles, until last or memory full.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {ACCEPT, WRITE, FINISHED} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t      state, state_next;
  logic        armed;
  logic        last_q;
  logic        full;
  logic        take;
  logic [31:0] packed_word;

  always_comb begin
    packed_word = '0;
    case (fmt)
      2'b00:   packed_word = {op, rs, rt, rd, shamt, funct};
      2'b01:   packed_word = {op, rs, rt, immediate};
      2'b10:   packed_word = {op, target};
      default: packed_word = '0;
    endcase
  end

  assign full = (im_addr == ADDR_MAX);

  // armed keeps in_ready low until the first clock edge after reset release
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    im_we      = 1'b0;
    done       = 1'b0;
    take       = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = armed;
        take     = in_valid & armed;
        if (take && fmt != 2'b11) state_next = WRITE;
      end
      WRITE: begin
        im_we      = 1'b1;
        state_next = (last_q || full) ? FINISHED : ACCEPT;
      end
      FINISHED: begin
        done = 1'b1;
        if (start) state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCEPT;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      err      <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (take) begin
            if (fmt == 2'b11) begin
              err <= 1'b1;
            end else begin
              im_wdata <= packed_word;
              last_q   <= last;
            end
          end
        end
        WRITE: begin
          count <= count + CNT_ONE;
          if (!(last_q || full)) im_addr <= im_addr + ADDR_ONE;
        end
        FINISHED: begin
          if (start) begin
            im_addr <= '0;
            count   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus random
// field sets checked against a transaction-level model of the loader.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, last;
  logic          in_ready, im_we, done, err;
  logic [1:0]    fmt;
  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   immediate;
  logic [25:0]   target;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // model state
  int unsigned m_addr, m_count;
  bit          m_done, m_err;

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .immediate(immediate), .target(target),
    .last(last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_word(input int unsigned f, input int unsigned o,
      input int unsigned s, input int unsigned t, input int unsigned d,
      input int unsigned sh, input int unsigned fn, input int unsigned imm,
      input int unsigned tg);
    if (f == 0) return o * 2**26 + s * 2**21 + t * 2**16 + d * 2**11 + sh * 2**6 + fn;
    if (f == 1) return o * 2**26 + s * 2**21 + t * 2**16 + imm;
    return o * 2**26 + tg;
  endfunction

  task automatic model_clear();
    m_addr = 0; m_count = 0; m_done = 0; m_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    model_clear();
    check("rst_we", {31'b0, im_we}, 0);
    check("rst_addr", 32'(im_addr), 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_count", 32'(count), 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    reset = 1'b0;
    #1 check("rdy_pre_clk", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    check("rdy_post_clk", {31'b0, in_ready}, 1);
  endtask

  // Called just after a rising edge; one offer of a field set.
  task automatic send(input int unsigned f, input int unsigned o, input int unsigned s,
      input int unsigned t, input int unsigned d, input int unsigned sh,
      input int unsigned fn, input int unsigned imm, input int unsigned tg, input bit l);
    int unsigned w;
    fmt = 2'(f); op = 6'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); shamt = 5'(sh);
    funct = 6'(fn); immediate = 16'(imm); target = 26'(tg); last = l;
    in_valid = 1'b1;
    check("ready_offer", {31'b0, in_ready}, {31'b0, !m_done});
    @(posedge clk); #1;
    if (m_done) begin
      check("done_no_we", {31'b0, im_we}, 0);
      check("done_hold", {31'b0, done}, 1);
      check("done_count", 32'(count), m_count);
      return;
    end
    if (f == 3) begin
      m_err = 1;
      check("ill_we", {31'b0, im_we}, 0);
      check("ill_err", {31'b0, err}, 1);
      check("ill_rdy", {31'b0, in_ready}, 1);
      check("ill_count", 32'(count), m_count);
      return;
    end
    w = ref_word(f, o, s, t, d, sh, fn, imm, tg);
    check("wr_we", {31'b0, im_we}, 1);
    check("wr_addr", 32'(im_addr), m_addr);
    check("wr_data", im_wdata, w);
    check("wr_rdy", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    m_count++;
    if (l || m_addr == DEPTH - 1) m_done = 1;
    else m_addr++;
    check("post_we", {31'b0, im_we}, 0);
    check("post_count", 32'(count), m_count);
    check("post_addr", 32'(im_addr), m_addr);
    check("post_done", {31'b0, done}, {31'b0, m_done});
    check("post_err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic rearm();
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (m_done) begin
      m_addr = 0; m_count = 0; m_done = 0;
    end
    check("arm_done", {31'b0, done}, {31'b0, m_done});
    check("arm_count", 32'(count), m_count);
    check("arm_addr", 32'(im_addr), m_addr);
    check("arm_err", {31'b0, err}, {31'b0, m_err});
    check("arm_rdy", {31'b0, in_ready}, {31'b0, !m_done});
  endtask

  task automatic send_random(input bit allow_last);
    int unsigned f;
    f = ($urandom_range(7) == 0) ? 3 : $urandom_range(2);
    send(f, $urandom_range(63), $urandom_range(31), $urandom_range(31),
         $urandom_range(31), $urandom_range(31), $urandom_range(63),
         $urandom_range(65535), $urandom & 32'h03FF_FFFF,
         allow_last && ($urandom_range(5) == 0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0; fmt = '0;
    op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    immediate = '0; target = '0;
    model_clear();
    do_reset();

    // addu $3,$1,$2
    send(0, 0, 1, 2, 3, 0, 'h21, 0, 0, 0);
    check("addu_word", im_wdata, 32'h0022_1821);

    // ori then j with last
    do_reset();
    send(1, 'h0D, 0, 1, 0, 0, 0, 'h1234, 0, 0);
    check("ori_word", im_wdata, 32'h3401_1234);
    send(2, 2, 0, 0, 0, 0, 0, 0, 'h0000C00, 1);
    check("j_word", im_wdata, 32'h0800_0C00);
    check("ij_done", {31'b0, done}, 1);
    check("ij_count", 32'(count), 2);
    send(0, 1, 1, 1, 1, 1, 1, 0, 0, 0);   // ignored in DONE
    in_valid = 1'b0;

    // illegal format, then legal write at addr 0
    rearm();
    send(3, 5, 5, 5, 5, 5, 5, 5, 5, 0);
    send(1, 8, 2, 3, 0, 0, 0, 'hBEEF, 0, 0);
    in_valid = 1'b0;
    start = 1'b1;                          // start has no effect outside DONE
    @(posedge clk); #1;
    start = 1'b0;
    check("start_idle_count", 32'(count), m_count);
    check("start_idle_addr", 32'(im_addr), m_addr);

    // full memory: four words with in_valid held, then a rejected fifth
    do_reset();
    for (int unsigned i = 0; i < DEPTH; i++)
      send(1, i, i, i, 0, 0, 0, i * 17, 0, 0);
    check("full_done", {31'b0, done}, 1);
    check("full_count", 32'(count), DEPTH);
    check("full_addr", 32'(im_addr), DEPTH - 1);
    send(0, 3, 3, 3, 3, 3, 3, 0, 0, 0);
    send(0, 3, 3, 3, 3, 3, 3, 0, 0, 0);
    in_valid = 1'b0;

    // re-arm keeps err
    send(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // ignored in DONE, err stays 0
    rearm();
    send(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send(0, 9, 9, 9, 9, 9, 9, 0, 0, 1);
    rearm();
    check("rearm_err_kept", {31'b0, err}, 1);
    send(2, 4, 0, 0, 0, 0, 0, 0, 'h3FF_FFFF, 0);
    check("rearm_count1", 32'(count), 1);

    // reset asserted mid-write
    fmt = 2'b00; op = 6'h01; last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mw_we_before", {31'b0, im_we}, 1);
    reset = 1'b1;
    #1;
    model_clear();
    check("mw_we_async", {31'b0, im_we}, 0);
    check("mw_count", 32'(count), 0);
    check("mw_addr", 32'(im_addr), 0);
    check("mw_err", {31'b0, err}, 0);
    #2 reset = 1'b0;
    #1 check("mw_rdy_pre", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    check("mw_rdy_post", {31'b0, in_ready}, 1);

    // randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      if (m_done) begin
        if ($urandom_range(2) == 0) send_random(1);
        else rearm();
        in_valid = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        start = 1'(($urandom_range(1)));
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_we", {31'b0, im_we}, 0);
        check("idle_rdy", {31'b0, in_ready}, 1);
        check("idle_count", 32'(count), m_count);
      end else begin
        send_random(1);
        if ($urandom_range(1) == 0) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
